wb_stage: RTL
=============

# wb_stage

Registered, parametrised writeback stage for the MIPS R2000 pipeline: it replaces the purely combinational writeback mux. It sits between the MEM/WB boundary and the register file. It accepts one retiring instruction per cycle through a valid/ready handshake and extracts and sign/zero-extends sub-word load data. It holds the pipeline when memory read data arrives late, and drives a registered register-file write port plus a same-cycle forwarding copy.

## Interface
- DATA_W, 32: datapath width. Must be a multiple of 8, minimum 16.
- REG_AW, 5: register address width.
- BIG_ENDIAN, 1: 1 means byte offset 0 maps to bits [DATA_W-1:DATA_W-8]. 0 means offset 0 maps to [7:0].
- TIMEOUT, 255: maximum cycles spent waiting for load data before an error is flagged. Range 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  stage can accept this cycle.
- reg_write_in  in  1  instruction writes a register.
- mem_to_reg  in  1  1 selects load data, 0 selects ALU result.
- ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ld_unsigned  in  1  zero-extend sub-word loads.
- alu_result  in  DATA_W  ALU result. Its low log2(DATA_W/8) bits are the load byte offset.
- dest_reg  in  REG_AW  destination register.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- reg_write  out  1  register-file write enable, one-cycle pulse.
- write_register  out  REG_AW  register-file write address.
- write_data_reg  out  DATA_W  register-file write data.
- fwd_valid, fwd_reg, fwd_data  out  1/REG_AW/DATA_W  same values as the three outputs above, for the hazard unit.
- load_timeout  out  1  sticky error flag.

## Operation
- There are two states: RUN and WAIT_LOAD.
- **RUN:**
  - in_ready = 1.
  - An accepted instruction (in_valid & in_ready) is a *load* if mem_to_reg = 1, otherwise it is a *pass*.
  - A pass registers its result into the output registers.
  - A load that arrives with mem_rvalid = 1 in the same cycle completes like a pass.
  - A load that arrives without mem_rvalid latches dest_reg, ld_size, ld_unsigned and the byte offset, clears the wait counter, and moves to WAIT_LOAD.
- **WAIT_LOAD:**
  - in_ready = 0.
  - When mem_rvalid = 1, the stage completes the held load and returns to RUN. The next instruction can be accepted in the cycle after completion.
  - The wait counter increments each cycle without mem_rvalid.
  - When the counter reaches TIMEOUT, load_timeout is set (sticky until rst), the held load is discarded with no write, and the stage returns to RUN.
- **Extraction:**
  - Offset k selects byte k, or halfword k/2, with ordering set by BIG_ENDIAN. Halfword offsets ignore bit 0.
  - Extension is sign extension unless ld_unsigned = 1. Word loads pass mem_rdata unmodified.
- **Write gating:** reg_write asserts only if reg_write_in = 1 and dest_reg != 0. Writes to register 0 are suppressed, but the instruction still retires.
- mem_rvalid is ignored in RUN when no load is being accepted.

## Timing
- Reset values: state RUN, reg_write = 0, fwd_valid = 0, write_register = 0, write_data_reg = 0, load_timeout = 0, wait counter 0. in_ready reads 1 immediately after reset.
- Pass, or load with data in the acceptance cycle N: outputs are valid in cycle N+1 for exactly one cycle. Throughput is 1 per cycle.
- Load whose data arrives in cycle M > N: outputs are valid in cycle M+1. in_ready is 0 from N+1 through M and 1 again in M+1.
- Timeout: load_timeout rises in the cycle after the counter reaches TIMEOUT. There is no write pulse for that load.
- When no write occurs, reg_write and fwd_valid are 0. write_register and write_data_reg hold their last values.
- Reset asserted mid-WAIT_LOAD aborts the load asynchronously. No write pulse is produced.
- All outputs are registered except in_ready, which is a combinational decode of state.

## Test plan
- Back-to-back passes, reg_write_in = 1: dest 3 with result 0x0000_1234, then dest 4 with result 0xDEAD_BEEF on consecutive cycles. Required response: two consecutive write pulses with those values, and in_ready held at 1.
- Load byte, BIG_ENDIAN = 1:
  - Offset 1, mem_rdata 0x1280_5678 in the same cycle, signed: writes 0xFFFF_FF80.
  - Repeat with ld_unsigned: writes 0x0000_0080.
- Late load half: offset 2, dest 7, mem_rvalid after 3 cycles with data 0xAAAA_8001, signed. Required response:
  - in_ready is 0 for 3 cycles.
  - A single write of 0xFFFF_8001 to r7 one cycle after mem_rvalid.
  - An in_valid held during the wait is accepted only after completion.
- Register 0: a pass to dest 0 with reg_write_in = 1 produces no reg_write pulse, and the next instruction is accepted normally.
- Timeout with TIMEOUT = 4: a load with no mem_rvalid sets load_timeout after 4 waiting cycles, produces no write, and restores in_ready. A later mem_rvalid is ignored.
- Reset during WAIT_LOAD: assert rst for 1 cycle. Required response: all outputs return to their reset values, state is RUN, and no write follows.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM/WB intake, memory read return, register-file write
// port with its forwarding copy, and the load timeout flag.
interface wb_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) ();
   logic              in_valid;
   logic              in_ready;
   logic              reg_write_in;
   logic              mem_to_reg;
   logic [1:0]        ld_size;
   logic              ld_unsigned;
   logic [DATA_W-1:0] alu_result;
   logic [REG_AW-1:0] dest_reg;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              reg_write;
   logic [REG_AW-1:0] write_register;
   logic [DATA_W-1:0] write_data_reg;
   logic              fwd_valid;
   logic [REG_AW-1:0] fwd_reg;
   logic [DATA_W-1:0] fwd_data;
   logic              load_timeout;

   modport master (
      output in_valid, reg_write_in, mem_to_reg, ld_size, ld_unsigned,
             alu_result, dest_reg, mem_rdata, mem_rvalid,
      input  in_ready, reg_write, write_register, write_data_reg,
             fwd_valid, fwd_reg, fwd_data, load_timeout
   );

   modport slave (
      input  in_valid, reg_write_in, mem_to_reg, ld_size, ld_unsigned,
             alu_result, dest_reg, mem_rdata, mem_rvalid,
      output in_ready, reg_write, write_register, write_data_reg,
             fwd_valid, fwd_reg, fwd_data, load_timeout
   );
endinterface

// File: rtl/wb_stage.sv
// Registered MIPS writeback stage: valid/ready intake, sub-word load extraction,
// a bounded wait for late load data, and a register-file write port plus forwarding copy.
module wb_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_AW     = 5,
   parameter bit          BIG_ENDIAN = 1'b1,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic      clk,
   input  logic      rst,
   wb_stage_if.slave bus
);
   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned OFF_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned SH_W   = $clog2(DATA_W);

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_WAIT_LOAD = 1'b1
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [REG_AW-1:0] r_ld_dest;
   logic              r_ld_we;
   logic [1:0]        r_ld_size;
   logic              r_ld_uns;
   logic [OFF_W-1:0]  r_ld_off;
   logic              r_reg_write;
   logic [REG_AW-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_timeout;

   logic              w_run;
   logic              w_in_we;
   logic [1:0]        w_sz;
   logic              w_uns;
   logic [OFF_W-1:0]  w_off;
   int unsigned       w_k;
   int unsigned       w_hb;
   logic [SH_W-1:0]   w_bsh;
   logic [SH_W-1:0]   w_hsh;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_fill_b;
   logic              w_fill_h;
   logic [DATA_W-1:0] w_ld_data;
   logic [CNT_W-1:0]  w_cnt_nxt;

   assign w_run     = (r_state == ST_RUN);
   assign w_in_we   = bus.reg_write_in & (bus.dest_reg != '0);
   assign w_cnt_nxt = r_cnt + CNT_W'(1);

   // While waiting, the held load's attributes steer extraction instead of the live inputs.
   assign w_sz  = w_run ? bus.ld_size                    : r_ld_size;
   assign w_uns = w_run ? bus.ld_unsigned                : r_ld_uns;
   assign w_off = w_run ? bus.alu_result[OFF_W-1:0]      : r_ld_off;
   assign w_k   = 32'(w_off);
   assign w_hb  = w_k & ~32'd1;

   // Bit position of the addressed byte / halfword; halfwords ignore offset bit 0.
   always_comb begin
      w_bsh = '0;
      w_hsh = '0;
      if (w_k < NBYTES)
         w_bsh = BIG_ENDIAN ? SH_W'((NBYTES - 1 - w_k) * 8) : SH_W'(w_k * 8);
      if (w_hb + 2 <= NBYTES)
         w_hsh = BIG_ENDIAN ? SH_W'((NBYTES - 2 - w_hb) * 8) : SH_W'(w_hb * 8);
   end

   always_comb begin
      w_byte   = 8'(bus.mem_rdata >> w_bsh);
      w_half   = 16'(bus.mem_rdata >> w_hsh);
      w_fill_b = ~w_uns & w_byte[7];
      w_fill_h = ~w_uns & w_half[15];
      case (w_sz)
         2'b00:   w_ld_data = DATA_W'(w_byte) | ({DATA_W{w_fill_b}} & ~DATA_W'(8'hFF));
         2'b01:   w_ld_data = DATA_W'(w_half) | ({DATA_W{w_fill_h}} & ~DATA_W'(16'hFFFF));
         default: w_ld_data = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_ld_dest   <= '0;
         r_ld_we     <= 1'b0;
         r_ld_size   <= '0;
         r_ld_uns    <= 1'b0;
         r_ld_off    <= '0;
         r_reg_write <= 1'b0;
         r_wr_reg    <= '0;
         r_wr_data   <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_reg_write <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (bus.in_valid) begin
                  if (!bus.mem_to_reg || bus.mem_rvalid) begin
                     if (w_in_we) begin
                        r_reg_write <= 1'b1;
                        r_wr_reg    <= bus.dest_reg;
                        r_wr_data   <= bus.mem_to_reg ? w_ld_data : bus.alu_result;
                     end
                  end else begin
                     r_ld_dest <= bus.dest_reg;
                     r_ld_we   <= w_in_we;
                     r_ld_size <= bus.ld_size;
                     r_ld_uns  <= bus.ld_unsigned;
                     r_ld_off  <= bus.alu_result[OFF_W-1:0];
                     r_cnt     <= '0;
                     r_state   <= ST_WAIT_LOAD;
                  end
               end
            end
            ST_WAIT_LOAD: begin
               if (bus.mem_rvalid) begin
                  if (r_ld_we) begin
                     r_reg_write <= 1'b1;
                     r_wr_reg    <= r_ld_dest;
                     r_wr_data   <= w_ld_data;
                  end
                  r_state <= ST_RUN;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  // Give up on the load: flag it and retire without a write.
                  if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                     r_timeout <= 1'b1;
                     r_state   <= ST_RUN;
                  end
               end
            end
         endcase
      end
   end

   assign bus.in_ready       = w_run;
   assign bus.reg_write      = r_reg_write;
   assign bus.write_register = r_wr_reg;
   assign bus.write_data_reg = r_wr_data;
   assign bus.fwd_valid      = r_reg_write;
   assign bus.fwd_reg        = r_wr_reg;
   assign bus.fwd_data       = r_wr_data;
   assign bus.load_timeout   = r_timeout;
endmodule
